// File: rtl/fwd_ctrl_unit.sv
// ---------------------------------------------------------------------------
// fwd_ctrl_unit
//
// Forwarding and load-use hazard control for the dual-issue core. The Branch
// (b) pipe and the Memory (m) pipe each carry a shadow copy of their
// destination tag {valid, we, rd} through EX, MEM and WB. The Memory pipe also
// carries an is_load flag through EX and MEM. The four ID source operands are
// compared against these tags, giving one forwarding select code per operand.
// A load-use stall is raised when load data is not ready yet.
//
// Ports:
//   i_clk, i_rst          rising-edge clock, synchronous active-high reset
//   i_freeze              hold every shadow stage (global pipeline hold)
//   i_flush               kill the ID pair, so a bubble enters EX
//   i_id_valid_b/_m       ID slot valid per pipe
//   i_id_we_b/_m          ID instruction writes rd
//   i_id_rd_b/_m          ID destination register
//   i_id_is_load_m        ID Memory-pipe instruction is a load
//   i_id_rs1_b/rs2_b/rs1_m/rs2_m  ID source registers
//   o_sel_rs1_b/rs2_b/rs1_m/rs2_m forwarding mux selects
//                          000 RF, 001 B-EX, 010 M-EX, 011 B-MEM,
//                          100 M-MEM, 101 B-WB, 110 M-WB
//   o_load_use_stall      hold ID/IF and insert a bubble into EX
// ---------------------------------------------------------------------------
module fwd_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_freeze,
  input  logic              i_flush,
  input  logic              i_id_valid_b,
  input  logic              i_id_valid_m,
  input  logic              i_id_we_b,
  input  logic              i_id_we_m,
  input  logic [REG_AW-1:0] i_id_rd_b,
  input  logic [REG_AW-1:0] i_id_rd_m,
  input  logic              i_id_is_load_m,
  input  logic [REG_AW-1:0] i_id_rs1_b,
  input  logic [REG_AW-1:0] i_id_rs2_b,
  input  logic [REG_AW-1:0] i_id_rs1_m,
  input  logic [REG_AW-1:0] i_id_rs2_m,
  output logic [SEL_W-1:0]  o_sel_rs1_b,
  output logic [SEL_W-1:0]  o_sel_rs2_b,
  output logic [SEL_W-1:0]  o_sel_rs1_m,
  output logic [SEL_W-1:0]  o_sel_rs2_m,
  output logic              o_load_use_stall
);

  localparam logic [SEL_W-1:0] SEL_RF    = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_B_EX  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_M_EX  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_B_MEM = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_M_MEM = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_B_WB  = SEL_W'(5);
  localparam logic [SEL_W-1:0] SEL_M_WB  = SEL_W'(6);

  typedef struct packed {
    logic              v;
    logic              we;
    logic [REG_AW-1:0] rd;
  } slot_t;

  slot_t r_ex_b, r_ex_m, r_mem_b, r_mem_m, r_wb_b, r_wb_m;
  logic  r_ex_ld, r_mem_ld;

  slot_t             w_id_b, w_id_m;
  logic [REG_AW-1:0] w_rs     [4];
  logic              w_slot_v [4];
  logic [SEL_W-1:0]  w_sel    [4];
  logic              w_stall;

  assign w_id_b = '{v: i_id_valid_b, we: i_id_we_b, rd: i_id_rd_b};
  assign w_id_m = '{v: i_id_valid_m, we: i_id_we_m, rd: i_id_rd_m};

  assign w_rs[0] = i_id_rs1_b;
  assign w_rs[1] = i_id_rs2_b;
  assign w_rs[2] = i_id_rs1_m;
  assign w_rs[3] = i_id_rs2_m;

  assign w_slot_v[0] = i_id_valid_b;
  assign w_slot_v[1] = i_id_valid_b;
  assign w_slot_v[2] = i_id_valid_m;
  assign w_slot_v[3] = i_id_valid_m;

  // x0 never matches, so it always falls through to the register file.
  function automatic logic f_hit(input slot_t s, input logic [REG_AW-1:0] rs);
    return s.v && s.we && (s.rd == rs) && (rs != '0);
  endfunction

  // The youngest producer wins. Within a stage, the Memory-pipe instruction
  // is younger than its Branch partner, so it is checked first. A load in
  // EX/MEM always stalls a valid consumer, whatever else matches. While reset
  // is high, the outputs are forced to their idle values.
  always_comb begin
    w_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_sel[i] = SEL_RF;
      if      (f_hit(r_ex_m,  w_rs[i])) w_sel[i] = SEL_M_EX;
      else if (f_hit(r_ex_b,  w_rs[i])) w_sel[i] = SEL_B_EX;
      else if (f_hit(r_mem_m, w_rs[i])) w_sel[i] = SEL_M_MEM;
      else if (f_hit(r_mem_b, w_rs[i])) w_sel[i] = SEL_B_MEM;
      else if (f_hit(r_wb_m,  w_rs[i])) w_sel[i] = SEL_M_WB;
      else if (f_hit(r_wb_b,  w_rs[i])) w_sel[i] = SEL_B_WB;

      if (w_slot_v[i] &&
          ((r_ex_ld  && f_hit(r_ex_m,  w_rs[i])) ||
           (r_mem_ld && f_hit(r_mem_m, w_rs[i])))) begin
        w_stall = 1'b1;
      end
    end
    if (i_rst) begin
      w_stall = 1'b0;
      for (int i = 0; i < 4; i++) w_sel[i] = SEL_RF;
    end
  end

  // Shadow pipeline. Freeze holds everything. A stall or a flush replaces the
  // ID pair with a bubble, while the older stages keep draining.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_b   <= '0;
      r_ex_m   <= '0;
      r_mem_b  <= '0;
      r_mem_m  <= '0;
      r_wb_b   <= '0;
      r_wb_m   <= '0;
      r_ex_ld  <= 1'b0;
      r_mem_ld <= 1'b0;
    end else if (!i_freeze) begin
      if (w_stall || i_flush) begin
        r_ex_b  <= '0;
        r_ex_m  <= '0;
        r_ex_ld <= 1'b0;
      end else begin
        r_ex_b  <= w_id_b;
        r_ex_m  <= w_id_m;
        r_ex_ld <= i_id_is_load_m;
      end
      r_mem_b  <= r_ex_b;
      r_mem_m  <= r_ex_m;
      r_mem_ld <= r_ex_ld;
      r_wb_b   <= r_mem_b;
      r_wb_m   <= r_mem_m;
    end
  end

  assign o_sel_rs1_b      = w_sel[0];
  assign o_sel_rs2_b      = w_sel[1];
  assign o_sel_rs1_m      = w_sel[2];
  assign o_sel_rs2_m      = w_sel[3];
  assign o_load_use_stall = w_stall;

endmodule

// File: doc/fwd_ctrl_unit.md
# fwd_ctrl_unit

- Generates the 3-bit per-operand select codes that drive the forwarding multiplexers of the dual-issue (Branch pipe + Memory pipe) core.
- Raises the load-use stall.
- Keeps a shadow pipeline of destination-register tags for both pipes across EX, MEM and WB.
- Compares those tags against the four source operands of the instruction pair in ID.

## Interface
Parameters:
- REG_AW, 5, register address width
- SEL_W, 3, forwarding select width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  global pipeline hold (e.g. cache miss); all shadow stages hold
- flush  in  1  branch redirect; the ID pair is killed (bubble enters EX)
- id_valid_b / id_valid_m  in  1  ID slot valid, Branch / Memory pipe
- id_we_b / id_we_m  in  1  ID instruction writes rd
- id_rd_b / id_rd_m  in  REG_AW  ID destination register
- id_is_load_m  in  1  ID Memory-pipe instruction is a load
- id_rs1_b, id_rs2_b, id_rs1_m, id_rs2_m  in  REG_AW  ID source registers
- sel_rs1_b, sel_rs2_b, sel_rs1_m, sel_rs2_m  out  SEL_W  forwarding select per operand
- load_use_stall  out  1  hold ID/IF, insert bubble into EX

## Operation
Shadow stages:
- EX, MEM and WB each hold {valid, we, rd} for both pipes.
- The Memory pipe additionally holds is_load.

Select codes (fixed):
- 000: register file
- 001: Branch EX
- 010: Memory EX
- 011: Branch MEM
- 100: Memory MEM
- 101: Branch WB
- 110: Memory WB
- 111: never driven

Match rule:
- A stage/pipe matches an operand when valid & we & rd == rs & rs != 0.
- x0 always selects 000.

Priority (youngest data wins):
- Branch EX > Memory EX > Branch MEM > Memory MEM > Branch WB > Memory WB.
- Within a stage the Memory-pipe instruction is the younger of the pair, so it wins over the Branch pipe at the same stage. The Memory-pipe code is therefore checked before the Branch-pipe code in each stage, which overrides the numeric list above.
- Effective order: Memory EX > Branch EX > Memory MEM > Branch MEM > Memory WB > Branch WB.

Load data is available only at Memory WB:
- A matching Memory-pipe load in EX or MEM asserts load_use_stall, provided the ID operand's slot is valid.
- A load match is never masked by an older match.
- Selects are don't-care while the stall is high.

Scope:
- Intra-pair dependencies (Memory slot reading the Branch slot's rd in the same pair) are the issue logic's responsibility and are not checked here.

Advance per clock edge, with priority rst > freeze > stall/flush > normal:
- rst: all valid bits clear.
- freeze: all stages hold, regardless of load_use_stall and flush.
- load_use_stall: EX receives a bubble; EX→MEM and MEM→WB advance; WB retires.
- flush (no stall): EX receives a bubble; the rest advance.
- Normal: ID→EX (valid = id_valid & ~flush), EX→MEM, MEM→WB.

## Timing
- Selects and load_use_stall are combinational from ID inputs and shadow registers: zero-cycle latency, valid before the ID/EX edge.
- Shadow registers update on the rising clk edge only.
- Reset values:
  - all shadow valid = 0
  - all four selects = 000
  - load_use_stall = 0
- After rst deasserts, the first ID pair sees only register-file selects.
- A load in EX with a dependent consumer in ID:
  - Stall for 2 cycles (load in EX, then MEM).
  - Third cycle: select 110, no stall.
- freeze during a stall: the stall stays asserted and the state holds. The stall count resumes after freeze drops.
- flush and load_use_stall in the same cycle: both force a bubble into EX; the stall persists while the load is in EX/MEM.
- rst mid-stall: load_use_stall is 0 in the next cycle.
- Same rd written by both pipes in one pair: the Memory-pipe code wins.

## Test plan
- Reset: hold rst 3 cycles with valid ID traffic → all selects 000, load_use_stall 0; all shadow stages invalid after release.
- Priority ladder: Branch pipe writes x5 (ALU op); next pair reads x5 in rs1_m → sel_rs1_m = 001, then 011, then 101 as the producer moves through EX/MEM/WB (consumer held via an unrelated freeze pattern); x0 reads stay 000.
- Same-stage conflict: both pipes write x7 in one pair; next pair reads x7 in rs2_b → 010; with an older x7 writer in MEM → still 010.
- Load-use: Memory-pipe load writes x9; next pair reads x9 in rs1_b → load_use_stall = 1 for 2 cycles, EX bubbles, then sel_rs1_b = 110, stall 0.
- Freeze/flush: freeze during the load stall holds the stall for N cycles, then 2 cycles total of unfrozen stall remain; flush with a writer in ID → that rd never matches in later cycles.
- Reset mid-operation: assert rst while a load is in MEM and a stall is pending → next cycle load_use_stall = 0 and selects 000.
